// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the 10-bit-address I2C slave: FSM state encoding,
// the 10-bit addressing header prefix, ACK/NACK line levels, the bit-counter
// value that marks the ACK slot, and small helper functions.
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        HDR_ACK,
        ADR_LO,
        ADR_LO_ACK,
        WR,
        WR_ACK,
        RD,
        RD_ACK
    } state_t;

    // First five bits of every 10-bit addressing header byte
    localparam logic [4:0] HDR_10BIT = 5'b11110;

    // Line levels in the ninth (acknowledge) clock
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // Bit counter value once all eight data bits of a byte have been clocked
    localparam logic [3:0] ACK_SLOT = 4'd8;

    // Header byte addresses us when it carries the 11110 prefix and our
    // two upper address bits; bit 0 is the R/W flag and is not compared.
    function automatic logic hdrMatch(input logic [7:0] hdrByte,
                                      input logic [1:0] adrHi);
        return (hdrByte[7:3] == HDR_10BIT) && (hdrByte[2:1] == adrHi);
    endfunction

    // Majority vote over three samples, used by the optional glitch filter
    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync
// Brings the asynchronous scl/sda lines into the clk domain and derives the
// bus events the slave FSM works from.
//
// Optional build macro: I2C_SLAVE10_GLITCH_FILTER_EN inserts a 3-sample
// majority filter after the synchronizers (two extra cycles of latency).
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset (all flops to 1 = idle bus)
//   scl_i      : raw bus clock
//   sda_i      : raw bus data
//   sda_o      : synchronized (and optionally filtered) sda level
//   scl_rise_o : one-cycle pulse on a scl 0->1 edge
//   scl_fall_o : one-cycle pulse on a scl 1->0 edge
//   start_o    : one-cycle pulse on sda 1->0 while scl stays high
//   stop_o     : one-cycle pulse on sda 0->1 while scl stays high
// ---------------------------------------------------------------------------
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);
    import i2c_pkg::*;

    logic [SYNC_STAGES-1:0] sclSync_q;
    logic [SYNC_STAGES-1:0] sdaSync_q;
    logic                   sclLvl;
    logic                   sdaLvl;
    logic                   sclPrev_q;
    logic                   sdaPrev_q;

    // Synchronizer chains; they reset high so an idle bus produces no events
    always_ff @(posedge clk) begin
        if (rst) begin
            sclSync_q <= '1;
            sdaSync_q <= '1;
        end else begin
            sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl_i};
            sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda_i};
        end
    end

`ifdef I2C_SLAVE10_GLITCH_FILTER_EN
    logic [2:0] sclFlt_q;
    logic [2:0] sdaFlt_q;

    // Three-sample windows; a single-cycle spike can never win the vote
    always_ff @(posedge clk) begin
        if (rst) begin
            sclFlt_q <= '1;
            sdaFlt_q <= '1;
        end else begin
            sclFlt_q <= {sclFlt_q[1:0], sclSync_q[SYNC_STAGES-1]};
            sdaFlt_q <= {sdaFlt_q[1:0], sdaSync_q[SYNC_STAGES-1]};
        end
    end

    assign sclLvl = maj3(sclFlt_q);
    assign sdaLvl = maj3(sdaFlt_q);
`else
    assign sclLvl = sclSync_q[SYNC_STAGES-1];
    assign sdaLvl = sdaSync_q[SYNC_STAGES-1];
`endif

    // Previous-sample flops for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclPrev_q <= sclLvl;
            sdaPrev_q <= sdaLvl;
        end
    end

    // START/STOP require scl high in both samples so that a data change
    // coinciding with a scl edge is never mistaken for a bus condition.
    assign sda_o      = sdaLvl;
    assign scl_rise_o = sclLvl & ~sclPrev_q;
    assign scl_fall_o = ~sclLvl & sclPrev_q;
    assign start_o    = sclLvl & sclPrev_q & sdaPrev_q & ~sdaLvl;
    assign stop_o     = sclLvl & sclPrev_q & ~sdaPrev_q & sdaLvl;

endmodule

// File: rtl/i2c_slave10.sv
// ---------------------------------------------------------------------------
// i2c_slave10
// I2C slave with a 10-bit own address. Supports master writes (header 11110xx0,
// low address byte, then data bytes) and master reads through a repeated
// START with header 11110xx1 after the write address phase. No clock
// stretching; sda is only ever pulled low or released.
//
// Optional build macro: I2C_SLAVE10_GLITCH_FILTER_EN (see i2c_bus_sync).
//
// Ports
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   scl     : bus clock from the master
//   sda     : open-drain bus data (driven 0 or z)
//   own_adr : own 10-bit address, captured at every START
//   rx_dat  : last received write byte
//   rx_vld  : one-cycle pulse when rx_dat updates
//   tx_dat  : next read byte, sampled in the cycle tx_req is high
//   tx_req  : one-cycle pulse requesting the next read byte
//   busy    : high while addressed (from low address match until STOP,
//             master NACK or a non-matching header)
// ---------------------------------------------------------------------------
module i2c_slave10 #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [9:0] own_adr,
    output logic [7:0] rx_dat,
    output logic       rx_vld,
    input  logic [7:0] tx_dat,
    output logic       tx_req,
    output logic       busy
);
    import i2c_pkg::*;

    logic       sdaLvl;
    logic       sclRise;
    logic       sclFall;
    logic       busStart;
    logic       busStop;

    state_t     state_q;
    logic [3:0] bitCnt_q;
    logic [3:0] bitCnt_d;
    logic [7:0] shift_q;
    logic [9:0] adr_q;
    logic       sdaOe_q;
    logic [7:0] rxDat_q;
    logic       rxVld_q;
    logic       txReq_q;
    logic       busy_q;
    logic       addressed_q;
    logic       rxBitTake;
    logic       byteDone;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl),
        .sda_i      (sda),
        .sda_o      (sdaLvl),
        .scl_rise_o (sclRise),
        .scl_fall_o (sclFall),
        .start_o    (busStart),
        .stop_o     (busStop)
    );

    // Open-drain output stage: only ever pull low
    assign sda = sdaOe_q ? 1'b0 : 1'bz;

    assign rx_dat = rxDat_q;
    assign rx_vld = rxVld_q;
    assign tx_req = txReq_q;
    assign busy   = busy_q;

    // Receive helpers: a data bit is taken on each scl rise until eight are
    // in; the byte is judged on the scl fall that closes the eighth bit so
    // that the ACK drive lands while scl is low.
    assign bitCnt_d  = bitCnt_q + 4'd1;
    assign rxBitTake = sclRise && (bitCnt_q != ACK_SLOT);
    assign byteDone  = sclFall && (bitCnt_q == ACK_SLOT);

    // Protocol FSM. START/STOP override everything; otherwise the state
    // reacts to scl edges. In the read path tx_req is issued on the scl fall
    // that ends the acknowledge, and the byte (plus its first bit on sda) is
    // taken one cycle later while tx_req is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            adr_q       <= '0;
            sdaOe_q     <= 1'b0;
            rxDat_q     <= '0;
            rxVld_q     <= 1'b0;
            txReq_q     <= 1'b0;
            busy_q      <= 1'b0;
            addressed_q <= 1'b0;
        end else begin
            rxVld_q <= 1'b0;
            txReq_q <= 1'b0;
            if (busStart) begin
                state_q  <= HDR;
                bitCnt_q <= '0;
                sdaOe_q  <= 1'b0;
                adr_q    <= own_adr;
            end else if (busStop) begin
                state_q     <= IDLE;
                bitCnt_q    <= '0;
                sdaOe_q     <= 1'b0;
                busy_q      <= 1'b0;
                addressed_q <= 1'b0;
            end else begin
                if (txReq_q) begin
                    shift_q <= tx_dat;
                    sdaOe_q <= (tx_dat[7] == ACK);
                end
                case (state_q)
                    IDLE: begin
                        bitCnt_q <= '0;
                    end
                    HDR: begin
                        if (rxBitTake) begin
                            shift_q  <= {shift_q[6:0], sdaLvl};
                            bitCnt_q <= bitCnt_d;
                        end else if (byteDone) begin
                            if (hdrMatch(shift_q, adr_q[9:8]) && (!shift_q[0] || addressed_q)) begin
                                sdaOe_q <= 1'b1;
                                state_q <= HDR_ACK;
                            end else begin
                                state_q  <= IDLE;
                                bitCnt_q <= '0;
                                if (!hdrMatch(shift_q, adr_q[9:8])) begin
                                    busy_q      <= 1'b0;
                                    addressed_q <= 1'b0;
                                end
                            end
                        end
                    end
                    HDR_ACK: begin
                        if (sclFall) begin
                            bitCnt_q <= '0;
                            if (shift_q[0]) begin
                                // ACK stays driven until the read byte arrives
                                txReq_q <= 1'b1;
                                state_q <= RD;
                            end else begin
                                sdaOe_q <= 1'b0;
                                state_q <= ADR_LO;
                            end
                        end
                    end
                    ADR_LO: begin
                        if (rxBitTake) begin
                            shift_q  <= {shift_q[6:0], sdaLvl};
                            bitCnt_q <= bitCnt_d;
                        end else if (byteDone) begin
                            if (shift_q == adr_q[7:0]) begin
                                sdaOe_q     <= 1'b1;
                                busy_q      <= 1'b1;
                                addressed_q <= 1'b1;
                                state_q     <= ADR_LO_ACK;
                            end else begin
                                state_q  <= IDLE;
                                bitCnt_q <= '0;
                            end
                        end
                    end
                    ADR_LO_ACK, WR_ACK: begin
                        if (sclFall) begin
                            sdaOe_q  <= 1'b0;
                            bitCnt_q <= '0;
                            state_q  <= WR;
                        end
                    end
                    WR: begin
                        if (rxBitTake) begin
                            shift_q  <= {shift_q[6:0], sdaLvl};
                            bitCnt_q <= bitCnt_d;
                        end else if (byteDone) begin
                            rxDat_q <= shift_q;
                            rxVld_q <= 1'b1;
                            sdaOe_q <= 1'b1;
                            state_q <= WR_ACK;
                        end
                    end
                    RD: begin
                        if (rxBitTake) begin
                            bitCnt_q <= bitCnt_d;
                        end else if (byteDone) begin
                            sdaOe_q <= 1'b0;
                            state_q <= RD_ACK;
                        end else if (sclFall && (bitCnt_q != 4'd0)) begin
                            shift_q <= {shift_q[6:0], 1'b0};
                            sdaOe_q <= (shift_q[6] == ACK);
                        end
                    end
                    RD_ACK: begin
                        // A fall here can only follow an ACK seen on the rise
                        if (sclRise && (sdaLvl == NACK)) begin
                            state_q     <= IDLE;
                            bitCnt_q    <= '0;
                            busy_q      <= 1'b0;
                            addressed_q <= 1'b0;
                        end else if (sclFall) begin
                            txReq_q  <= 1'b1;
                            bitCnt_q <= '0;
                            state_q  <= RD;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave10.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave10
// Bit-level I2C master model driving i2c_slave10 (own address 10'h2A5).
// Written bytes are queued as expected rx_dat values and popped when rx_vld
// pulses; read bytes are queued when tx_dat is presented and popped when the
// master has clocked the byte in.
// ---------------------------------------------------------------------------
module tb_i2c_slave10;

    localparam int Q = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       mDrvLow;
    logic [9:0] ownAdr;
    logic [7:0] txDat;
    wire  [7:0] rxDat;
    wire        rxVld;
    wire        txReq;
    wire        busy;
    wire        sdaBus;

    int checks      = 0;
    int failures    = 0;
    int rxCount     = 0;
    int txReqCount  = 0;
    int expRxCount  = 0;
    int expTxReq    = 0;
    logic [7:0] expRxQ[$];
    logic [7:0] expRdQ[$];

    assign sdaBus = mDrvLow ? 1'b0 : 1'bz;
    pullup (sdaBus);

    i2c_slave10 #(
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .scl     (scl),
        .sda     (sdaBus),
        .own_adr (ownAdr),
        .rx_dat  (rxDat),
        .rx_vld  (rxVld),
        .tx_dat  (txDat),
        .tx_req  (txReq),
        .busy    (busy)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    // Hard time limit so a stuck bench still ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every rx_vld pulse
    always @(negedge clk) begin
        if (txReq) txReqCount++;
        if (rxVld) begin
            rxCount++;
            checkOutput("rx_pulse_expected", 32'(expRxQ.size() != 0), 32'd1);
            if (expRxQ.size() != 0) checkOutput("rx_dat", 32'(rxDat), 32'(expRxQ.pop_front()));
        end
    end

    task automatic waitQ();
        repeat (Q) @(negedge clk);
    endtask

    task automatic applyStimulus(input string kind);
        if (kind == "start") begin
            scl = 1'b1; mDrvLow = 1'b0; waitQ();
            mDrvLow = 1'b1; waitQ();
            scl = 1'b0; waitQ();
        end else if (kind == "rstart") begin
            mDrvLow = 1'b0; waitQ();
            scl = 1'b1; waitQ();
            mDrvLow = 1'b1; waitQ();
            scl = 1'b0; waitQ();
        end else begin
            mDrvLow = 1'b1; waitQ();
            scl = 1'b1; waitQ();
            mDrvLow = 1'b0; waitQ();
        end
    endtask

    task automatic writeBit(input logic b);
        mDrvLow = ~b; waitQ();
        scl = 1'b1; waitQ(); waitQ();
        scl = 1'b0; waitQ();
    endtask

    task automatic readBit(output logic b);
        mDrvLow = 1'b0; waitQ();
        scl = 1'b1; waitQ();
        b = sdaBus; waitQ();
        scl = 1'b0; waitQ();
    endtask

    task automatic writeByte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) writeBit(d[i]);
        readBit(ack);
    endtask

    task automatic readByte(output logic [7:0] d);
        for (int i = 7; i >= 0; i--) readBit(d[i]);
    endtask

    initial begin : main
        logic       ack;
        logic [7:0] rd;

        rst = 1'b1; scl = 1'b1; mDrvLow = 1'b0; ownAdr = 10'h2A5; txDat = 8'h00;
        repeat (5) @(negedge clk);
        checkOutput("reset_rx_vld", 32'(rxVld), 32'd0);
        checkOutput("reset_tx_req", 32'(txReq), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_sda_released", 32'(sdaBus), 32'd1);
        checkOutput("reset_rx_dat", 32'(rxDat), 32'h00);
        rst = 1'b0;
        waitQ();

        $display("[TB] write header, low address and one data byte");
        applyStimulus("start");
        writeByte(8'hF4, ack); checkOutput("wr_hdr_ack", 32'(ack), 32'd0);
        writeByte(8'hA5, ack); checkOutput("wr_adr_ack", 32'(ack), 32'd0);
        checkOutput("wr_busy_set", 32'(busy), 32'd1);
        expRxQ.push_back(8'h3C); expRxCount++;
        writeByte(8'h3C, ack); checkOutput("wr_data_ack", 32'(ack), 32'd0);
        applyStimulus("stop");
        checkOutput("wr_busy_after_stop", 32'(busy), 32'd0);
        checkOutput("wr_rx_dat_held", 32'(rxDat), 32'h3C);
        checkOutput("wr_rx_pulses", 32'(rxCount), 32'(expRxCount));

        $display("[TB] combined read after repeated START");
        applyStimulus("start");
        writeByte(8'hF4, ack); checkOutput("rd_wr_hdr_ack", 32'(ack), 32'd0);
        writeByte(8'hA5, ack); checkOutput("rd_adr_ack", 32'(ack), 32'd0);
        applyStimulus("rstart");
        txDat = 8'h96; expRdQ.push_back(8'h96); expTxReq++;
        writeByte(8'hF5, ack); checkOutput("rd_hdr_ack", 32'(ack), 32'd0);
        readByte(rd);
        checkOutput("rd_byte", 32'(rd), 32'(expRdQ.pop_front()));
        writeBit(1'b1);
        checkOutput("rd_busy_after_nack", 32'(busy), 32'd0);
        checkOutput("rd_tx_req_pulses", 32'(txReqCount), 32'(expTxReq));
        applyStimulus("stop");

        $display("[TB] low address mismatch");
        applyStimulus("start");
        writeByte(8'hF4, ack); checkOutput("mis_hdr_ack", 32'(ack), 32'd0);
        writeByte(8'hA6, ack); checkOutput("mis_adr_nack", 32'(ack), 32'd1);
        checkOutput("mis_busy", 32'(busy), 32'd0);
        applyStimulus("stop");

        $display("[TB] read header without prior write address");
        applyStimulus("start");
        writeByte(8'hF5, ack); checkOutput("noadr_rd_nack", 32'(ack), 32'd1);
        checkOutput("noadr_tx_req_pulses", 32'(txReqCount), 32'(expTxReq));
        applyStimulus("stop");

        $display("[TB] STOP after four data bits");
        applyStimulus("start");
        writeByte(8'hF4, ack); checkOutput("part_hdr_ack", 32'(ack), 32'd0);
        writeByte(8'hA5, ack); checkOutput("part_adr_ack", 32'(ack), 32'd0);
        writeBit(1'b1); writeBit(1'b0); writeBit(1'b1); writeBit(1'b1);
        applyStimulus("stop");
        checkOutput("part_busy", 32'(busy), 32'd0);
        checkOutput("part_rx_pulses", 32'(rxCount), 32'(expRxCount));

        $display("[TB] reset during read data");
        applyStimulus("start");
        writeByte(8'hF4, ack); checkOutput("rst_hdr_ack", 32'(ack), 32'd0);
        writeByte(8'hA5, ack); checkOutput("rst_adr_ack", 32'(ack), 32'd0);
        applyStimulus("rstart");
        txDat = 8'h5A; expTxReq++;
        writeByte(8'hF5, ack); checkOutput("rst_rd_hdr_ack", 32'(ack), 32'd0);
        mDrvLow = 1'b0; waitQ();
        scl = 1'b1; waitQ();
        checkOutput("rst_rd_bit7_low", 32'(sdaBus), 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_sda_released", 32'(sdaBus), 32'd1);
        checkOutput("rst_busy_cleared", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        waitQ();
        checkOutput("rst_tx_req_pulses", 32'(txReqCount), 32'(expTxReq));
        checkOutput("rst_rx_dat_cleared", 32'(rxDat), 32'h00);

`ifdef I2C_SLAVE10_GLITCH_FILTER_EN
        $display("[TB] single-cycle sda glitch while scl high");
        @(negedge clk) mDrvLow = 1'b1;
        @(negedge clk) mDrvLow = 1'b0;
        waitQ();
        scl = 1'b0; waitQ();
        writeByte(8'hF4, ack); checkOutput("glitch_no_start", 32'(ack), 32'd1);
        applyStimulus("stop");
`endif

        checkOutput("rx_queue_drained", 32'(expRxQ.size()), 32'd0);
        checkOutput("final_rx_pulses", 32'(rxCount), 32'(expRxCount));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_slave10.md
I2C_SLAVE10 -- requirements
Module: i2c_slave10

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of input synchronizer flops on scl and sda; legal range 2 to 3.
REQ-002 Port clk, input, 1 bit: the only clock; all logic is rising-edge clocked.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Port scl, input, 1 bit: bus clock driven by the master; never driven by this block (no clock stretching).
REQ-005 Port sda, inout, 1 bit: open-drain data line; the block drives only 1'b0, otherwise it drives 1'bz.
REQ-006 Port own_adr, input, 10 bits: own 10-bit slave address; sampled at every START.
REQ-007 Port rx_dat, output, 8 bits: last received write byte.
REQ-008 Port rx_vld, output, 1 bit: one-cycle pulse when rx_dat updates.
REQ-009 Port tx_dat, input, 8 bits: read byte; sampled in the cycle tx_req=1.
REQ-010 Port tx_req, output, 1 bit: one-cycle pulse requesting the next read byte.
REQ-011 Port busy, output, 1 bit: high from an addressed match until STOP, NACK exit or a non-matching START.

Function
REQ-012 scl and sda shall pass through SYNC_STAGES flops, followed by one edge-detect flop; all decisions use the synchronized values.
REQ-013 START shall be a synchronized sda 1->0 edge while scl=1; STOP shall be a sda 0->1 edge while scl=1.
REQ-014 Bits shall be sampled MSB first on the scl rising edge.
REQ-015 Driven sda changes shall occur only in the cycle after a detected scl falling edge.
REQ-016 States: IDLE, HDR, HDR_ACK, ADR_LO, ADR_LO_ACK, WR, WR_ACK, RD, RD_ACK.
REQ-017 On START from any state, the block shall go to HDR and the bit counter shall be cleared.
REQ-018 On STOP from any state, the block shall go to IDLE and release sda.
REQ-019 HDR: the byte shall match when bits[7:3]=5'b11110 and bits[2:1]=own_adr[9:8].
REQ-020 HDR, R/W=0 with a match: go to HDR_ACK and drive ACK (sda=0) for the 9th clock.
REQ-021 HDR, R/W=0 without a match: return to IDLE without ACK.
REQ-022 ADR_LO: a byte equal to own_adr[7:0] shall be ACKed, set busy and set an internal addressed flag, then go to WR; a mismatch shall go to IDLE, no ACK.
REQ-023 WR: after the 8th bit, load rx_dat, pulse rx_vld for exactly one cycle, ACK, and return to WR.
REQ-024 HDR, R/W=1 with a match and the addressed flag set (repeated START after a 10-bit write address): ACK and go to RD.
REQ-025 HDR, R/W=1 with the addressed flag clear: return to IDLE without ACK.
REQ-026 RD: pulse tx_req on the scl falling edge that ends the ACK, load the shift register from tx_dat in that cycle, then drive the 8 bits.
REQ-027 RD_ACK: master ACK (sda=0) shall continue RD; master NACK shall release sda, go to IDLE and clear busy and the addressed flag.
REQ-028 The addressed flag shall clear on STOP, reset or a HDR mismatch.
REQ-029 STOP or START mid-byte shall discard the partial byte; no rx_vld pulse shall be produced.
REQ-030 The bit counter shall be 4 bits wide, counting 0..8 per byte (8 = ACK slot), and shall wrap to 0.

Reset
REQ-031 While rst=1: state=IDLE, sda released (z), rx_dat=8'h00, rx_vld=0, tx_req=0, busy=0, addressed flag=0, counters=0, synchronizers=1.
REQ-032 Reset asserted mid-transfer shall release sda on the first clk edge with rst=1.

Configuration
REQ-033 Macro I2C_SLAVE10_GLITCH_FILTER_EN defined: a 3-sample majority filter shall be inserted after the synchronizers on scl and sda, adding 2 cycles of latency.
REQ-034 I2C_SLAVE10_GLITCH_FILTER_EN undefined: no filter; synchronizer output feeds edge detection directly.

Structure
REQ-035 Package i2c_pkg shall hold the state encoding, the 5'b11110 header constant, ACK=1'b0 and NACK=1'b1.
REQ-036 Sub-module i2c_bus_sync shall contain the synchronizers, the optional filter and START/STOP/edge detection, outputting scl_rise, scl_fall, start and stop pulses.

Verification
REQ-037 own_adr=10'h2A5; START, 0xF4, 0xA5, 0x3C, STOP -> three ACKs, rx_dat=0x3C with one rx_vld pulse, busy low after STOP.
REQ-038 own_adr=10'h2A5; START, 0xF4, 0xA6 -> ACK on the header only, NACK on the second byte, state IDLE, busy=0.
REQ-039 After REQ-037 address phase, repeated START, 0xF5, tx_dat=0x96, master NACK -> header ACKed, one tx_req, sda bits 1,0,0,1,0,1,1,0, then IDLE.
REQ-040 START, 0xF5 with no prior write address -> no ACK, tx_req never pulses.
REQ-041 STOP after 4 bits of a write byte -> no rx_vld, IDLE; rst=1 during RD -> sda=z the next cycle.
REQ-042 With I2C_SLAVE10_GLITCH_FILTER_EN, a 1-cycle low pulse on sda while scl=1 -> no START detected.
